if_fetch_buffer: RTL and testbench
==================================

Name: if_fetch_buffer

Overview:
- Small in-order FIFO between the PC register and instruction memory (upstream) and the IF/ID boundary (downstream).
- Captures each fetched {pc, instruction} pair and presents the oldest pair to decode with a valid flag.
- Absorbs decode stalls without losing fetched instructions.
- Drives the PC hold signal, 1 = hold, the same polarity as the PC's PCWrite_i.

Parameters:
- DEPTH, 2, number of buffer entries; must be a power of two and at least 2.
- AW, 32, width of PC and instruction words.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- fetch_valid_i  in  1  pc_i/instr_i carry a fetched instruction this cycle (PC start_i and memory ready).
- pc_i  in  AW  address of the fetched instruction (PC register output).
- instr_i  in  AW  instruction word read combinationally from instruction memory at pc_i.
- stall_i  in  1  decode cannot accept this cycle (hazard unit).
- flush_i  in  1  discard all buffered and incoming instructions (taken branch/jump).
- valid_o  out  1  head entry is valid.
- pc_o  out  AW  PC of head entry.
- instr_o  out  AW  instruction of head entry.
- hold_pc_o  out  1  1 = PC must hold its value (buffer full); connects to PC PCWrite_i.
- count_o  out  $clog2(DEPTH)+1  current occupancy.
- is_branch_o  out  1  head instruction is a branch (see Optional Feature).

Behaviour:
Reset:
- Synchronous, active-high. On rst_i=1 at a rising edge: count=0, read/write pointers=0, all storage cleared to 0.
- Reset overrides flush, push and pop in the same cycle.
- Outputs after reset: valid_o=0, pc_o=0, instr_o=0, hold_pc_o=0, count_o=0, is_branch_o=0.

Push and pop:
- push = fetch_valid_i & ~hold_pc_o & ~flush_i.
- pop = valid_o & ~stall_i & ~flush_i.
- Push writes {pc_i, instr_i} at the write pointer; the pointer increments modulo DEPTH.
- Pop increments the read pointer modulo DEPTH.
- Pointers wrap naturally; occupancy is tracked by an explicit counter, not pointer comparison.
- count_next = count + push - pop. Simultaneous push and pop leaves count unchanged.

Outputs:
- valid_o = (count != 0).
- When valid, pc_o/instr_o = storage[read pointer]. When not valid, pc_o=0 and instr_o=0 (NOP).
- Outputs depend only on registered state, so there is no combinational path from any input to any output.
- Latency: an instruction pushed at edge N appears on valid_o/instr_o after edge N, i.e. in cycle N+1. There is no bypass.

Full:
- hold_pc_o = (count == DEPTH), derived from the registered count.
- When full, push is blocked even if a pop occurs the same cycle. The PC sees hold one cycle, then resumes. This rule breaks the stall_i→PC timing path.

Empty:
- valid_o=0; stall_i is ignored; no pop.

Flush:
- flush_i=1 sets count=0 and both pointers=0 at the next edge.
- The same-cycle fetch is dropped and no pop is reported.
- Storage contents need not be cleared, but outputs must read 0 while empty.
- Flush while full: hold_pc_o deasserts the next cycle.

Stall while full with fetch_valid_i=1:
- State is unchanged; hold_pc_o stays 1.

Optional Feature:
- Macro IFB_PREDECODE_EN.
- Defined: each entry stores an extra bit, set when instr[31:26] == 6'b000100 (beq) at push time. is_branch_o = valid_o & stored bit of the head entry.
- Not defined: no extra storage; is_branch_o tied to 0.
- All other behaviour is identical in both configurations.

Decomposition:
- Shared package holds:
  - OPC_BEQ = 6'b000100.
  - NOP_WORD = 32'h0000_0000.
  - An entry typedef/struct {pc, instr[, br]}.
- One natural sub-module: ifb_storage, a DEPTH×entry register array with a write port and one async read port. Pointer and count control stays in the top module.

Test Plan:
- Reset: rst_i=1 for 2 cycles with fetch_valid_i=1 → valid_o=0, count_o=0, hold_pc_o=0, instr_o=0.
- Streaming: fetch pc 0,4,8 (instr 0x20080001, 0x20090002, 0x200A0003) with stall_i=0 → each appears one cycle later in order; count_o stays 1; hold_pc_o=0 throughout.
- Fill/full: stall_i=1, push pc 0 and 4 → count_o=2 and hold_pc_o=1. A third fetch at pc 8 is ignored. Release stall_i → head pc 0; hold_pc_o is still 1 that cycle (no same-cycle push), then pc 4 and resumed pc 8 follow.
- Flush: buffer holds pc 0x10 and 0x14 (full); flush_i=1 with fetch pc 0x18 → next cycle valid_o=0, count_o=0, hold_pc_o=0, and 0x18 is not captured.
- Wrap-around: 10 pushes/pops with alternating stall_i → pointers wrap past DEPTH; output order equals input order; no loss or duplication.
- Predecode (IFB_PREDECODE_EN): push 0x1108FFFF (beq) → is_branch_o=1 when it reaches head; push 0x20080001 → is_branch_o=0. With the macro off, is_branch_o=0 for both.

Source files
------------

// File: rtl/if_fetch_buffer_pkg.sv
// Shared types and constants for the IF fetch buffer.
// IFB_PREDECODE_EN adds a per-entry branch predecode bit.
package if_fetch_buffer_pkg;

  localparam int unsigned IFB_AW = 32;
  localparam logic [5:0] OPC_BEQ = 6'b000100;
  localparam logic [IFB_AW-1:0] NOP_WORD = 32'h0000_0000;

  typedef struct packed {
    logic [IFB_AW-1:0] pc;
    logic [IFB_AW-1:0] instr;
`ifdef IFB_PREDECODE_EN
    logic              br;
`endif
  } ifb_entry_t;

  function automatic logic is_beq(input logic [IFB_AW-1:0] instr);
    return instr[31:26] == OPC_BEQ;
  endfunction

endpackage

// File: rtl/ifb_storage.sv
// DEPTH-entry register array: one synchronous write port, one async read port.
module ifb_storage
  import if_fetch_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned PW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [PW-1:0] waddr_i,
  input  ifb_entry_t    wdata_i,
  input  logic [PW-1:0] raddr_i,
  output ifb_entry_t    rdata_o
);

  ifb_entry_t mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_fetch_buffer.sv
// In-order {pc, instr} FIFO between fetch and decode; holds the PC while full.
// IFB_PREDECODE_EN enables the is_branch_o predecode output.
module if_fetch_buffer
  import if_fetch_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = IFB_AW
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     fetch_valid_i,
  input  logic [AW-1:0]            pc_i,
  input  logic [AW-1:0]            instr_i,
  input  logic                     stall_i,
  input  logic                     flush_i,
  output logic                     valid_o,
  output logic [AW-1:0]            pc_o,
  output logic [AW-1:0]            instr_o,
  output logic                     hold_pc_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     is_branch_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("if_fetch_buffer: DEPTH must be a power of two >= 2");
  end
  if (AW != IFB_AW) begin : g_bad_aw
    $error("if_fetch_buffer: AW must equal IFB_AW");
  end

  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  logic          push_c, pop_c;
  ifb_entry_t    wr_entry, rd_entry;

  // Full blocks push even with a same-cycle pop, keeping stall_i off the PC path.
  assign hold_pc_o = (count_q == CW'(DEPTH));
  assign valid_o   = (count_q != '0);
  assign count_o   = count_q;
  assign push_c    = fetch_valid_i & ~hold_pc_o & ~flush_i;
  assign pop_c     = valid_o & ~stall_i & ~flush_i;

  always_comb begin
    wr_entry       = '0;
    wr_entry.pc    = IFB_AW'(pc_i);
    wr_entry.instr = IFB_AW'(instr_i);
`ifdef IFB_PREDECODE_EN
    wr_entry.br    = is_beq(IFB_AW'(instr_i));
`endif
  end

  ifb_storage #(
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_storage (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (push_c),
    .waddr_i (wptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rptr_q),
    .rdata_o (rd_entry)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_c) wptr_q <= wptr_q + PW'(1);
      if (pop_c)  rptr_q <= rptr_q + PW'(1);
      count_q <= count_q + CW'(push_c) - CW'(pop_c);
    end
  end

  // Empty buffer presents a NOP at pc 0.
  assign pc_o    = valid_o ? AW'(rd_entry.pc)    : '0;
  assign instr_o = valid_o ? AW'(rd_entry.instr) : AW'(NOP_WORD);

`ifdef IFB_PREDECODE_EN
  assign is_branch_o = valid_o & rd_entry.br;
`else
  assign is_branch_o = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch_buffer.sv
// Directed bench for if_fetch_buffer with a queue scoreboard of buffered entries.
module tb_if_fetch_buffer;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned AW    = 32;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        br;
  } exp_t;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          fetch_valid_i = 1'b0;
  logic [AW-1:0] pc_i = '0;
  logic [AW-1:0] instr_i = '0;
  logic          stall_i = 1'b0;
  logic          flush_i = 1'b0;
  logic          valid_o;
  logic [AW-1:0] pc_o;
  logic [AW-1:0] instr_o;
  logic          hold_pc_o;
  logic [1:0]    count_o;
  logic          is_branch_o;

  int   tests = 0;
  int   fails = 0;
  exp_t q[$];

  if_fetch_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .fetch_valid_i (fetch_valid_i),
    .pc_i          (pc_i),
    .instr_i       (instr_i),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .valid_o       (valid_o),
    .pc_o          (pc_o),
    .instr_o       (instr_o),
    .hold_pc_o     (hold_pc_o),
    .count_o       (count_o),
    .is_branch_o   (is_branch_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_br(input logic [31:0] instr);
`ifdef IFB_PREDECODE_EN
    return instr[31:26] == 6'b000100;
`else
    return 1'b0;
`endif
  endfunction

  // Compare DUT head and status against the scoreboard.
  task automatic check_state(input string tag);
    logic [31:0] epc, ein;
    logic        ebr;
    epc = '0; ein = '0; ebr = 1'b0;
    if (q.size() != 0) begin
      epc = q[0].pc; ein = q[0].instr; ebr = q[0].br;
    end
    chk({tag, ".valid"}, 32'(valid_o),     32'(q.size() != 0));
    chk({tag, ".pc"},    pc_o,             epc);
    chk({tag, ".instr"}, instr_o,          ein);
    chk({tag, ".count"}, 32'(count_o),     32'(q.size()));
    chk({tag, ".hold"},  32'(hold_pc_o),   32'(q.size() == DEPTH));
    chk({tag, ".br"},    32'(is_branch_o), 32'(ebr));
  endtask

  // One clock: drive inputs, check, update scoreboard, advance past the edge.
  task automatic step(input string tag, input logic fv, input logic [31:0] pc,
                      input logic [31:0] ins, input logic st, input logic fl,
                      output logic pushed);
    exp_t e, popped;
    logic m_push, m_pop;
    fetch_valid_i = fv; pc_i = pc; instr_i = ins; stall_i = st; flush_i = fl;
    #1;
    check_state(tag);
    m_push = fv && (q.size() != DEPTH) && !fl;
    m_pop  = (q.size() != 0) && !st && !fl;
    if (m_pop) begin
      popped = q.pop_front();
      chk({tag, ".pop_pc"}, pc_o, popped.pc);
      chk({tag, ".pop_in"}, instr_o, popped.instr);
    end
    if (fl) q.delete();
    if (m_push) begin
      e.pc = pc; e.instr = ins; e.br = exp_br(ins);
      q.push_back(e);
    end
    pushed = m_push;
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  initial begin
    logic        p;
    int          k;
    logic [31:0] wrap_in [10];

    // Reset with fetch_valid_i high for two cycles.
    rst_i = 1'b1; fetch_valid_i = 1'b1; pc_i = 32'h40; instr_i = 32'h2008_0001;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    q.delete();
    chk("rst.valid", 32'(valid_o),   32'd0);
    chk("rst.count", 32'(count_o),   32'd0);
    chk("rst.hold",  32'(hold_pc_o), 32'd0);
    chk("rst.instr", instr_o,        32'd0);
    chk("rst.pc",    pc_o,           32'd0);
    chk("rst.br",    32'(is_branch_o), 32'd0);
    rst_i = 1'b0;

    // Streaming without stall.
    step("s0", 1'b1, 32'h0, 32'h2008_0001, 1'b0, 1'b0, p);
    step("s1", 1'b1, 32'h4, 32'h2009_0002, 1'b0, 1'b0, p);
    step("s2", 1'b1, 32'h8, 32'h200A_0003, 1'b0, 1'b0, p);
    chk("stream.count", 32'(count_o), 32'd1);
    step("s3", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, p);
    step("s4", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, p);

    // Fill under stall, blocked third fetch, release.
    step("f0", 1'b1, 32'h0, 32'h2008_0001, 1'b1, 1'b0, p);
    step("f1", 1'b1, 32'h4, 32'h2009_0002, 1'b1, 1'b0, p);
    chk("full.hold", 32'(hold_pc_o), 32'd1);
    step("f2", 1'b1, 32'h8, 32'h200A_0003, 1'b1, 1'b0, p);
    chk("full.ignored", 32'(p), 32'd0);
    step("f3", 1'b1, 32'h8, 32'h200A_0003, 1'b0, 1'b0, p);
    chk("full.nopush", 32'(p), 32'd0);
    step("f4", 1'b1, 32'h8, 32'h200A_0003, 1'b0, 1'b0, p);
    step("f5", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, p);
    step("f6", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, p);

    // Flush while full.
    step("x0", 1'b1, 32'h10, 32'h2008_0010, 1'b1, 1'b0, p);
    step("x1", 1'b1, 32'h14, 32'h2008_0014, 1'b1, 1'b0, p);
    step("x2", 1'b1, 32'h18, 32'h2008_0018, 1'b1, 1'b1, p);
    chk("flush.valid", 32'(valid_o),   32'd0);
    chk("flush.count", 32'(count_o),   32'd0);
    chk("flush.hold",  32'(hold_pc_o), 32'd0);
    step("x3", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, p);

    // Wrap-around: PC holds until each fetch is accepted.
    for (int i = 0; i < 10; i++) wrap_in[i] = $urandom;
    k = 0;
    for (int c = 0; c < 60 && k < 10; c++) begin
      step("w", 1'b1, 32'h100 + 32'(k) * 4, wrap_in[k], 1'(c % 2), 1'b0, p);
      if (p) k++;
    end
    chk("wrap.accepted", 32'(k), 32'd10);
    for (int c = 0; c < 6; c++) step("wd", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, p);
    chk("wrap.drained", 32'(count_o), 32'd0);

    // Predecode: beq then addi.
    step("b0", 1'b1, 32'h200, 32'h1108_FFFF, 1'b1, 1'b0, p);
    step("b1", 1'b1, 32'h204, 32'h2008_0001, 1'b1, 1'b0, p);
    chk("br.beq", 32'(is_branch_o), 32'(exp_br(32'h1108_FFFF)));
    step("b2", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, p);
    chk("br.addi", 32'(is_branch_o), 32'd0);
    step("b3", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, p);
    step("b4", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, p);

    // Reset overrides a same-cycle push.
    fetch_valid_i = 1'b1; rst_i = 1'b1; pc_i = 32'h300; instr_i = 32'h1;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0; fetch_valid_i = 1'b0;
    chk("rst2.count", 32'(count_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
